// File: rtl/prog_clkdiv_pkg.sv
// Shared constants and helpers for the programmable clock divider.
// Holds the divisor clamp and the channel-index width calculation.
package prog_clkdiv_pkg;

    localparam int DIV_MIN = 2;

    // A divisor of 0 or 1 cannot form a period with both a low and a high phase.
    function automatic logic [31:0] clamp_div(input logic [31:0] d);
        return (d < 32'(DIV_MIN)) ? 32'(DIV_MIN) : d;
    endfunction

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/prog_clkdiv_chan.sv
// One divider channel: counter, active and pending divisor, registered clk_out and tick.
// A pending divisor is applied only at a wrap, a sync, or while the channel is disabled.
module prog_clkdiv_chan #(
    parameter int CNT_W       = 16,
    parameter int DEFAULT_DIV = 2
) (
    input  logic             clk_in,
    input  logic             reset,
    input  logic             en,
    input  logic             sync,
    input  logic             wr,
    input  logic [CNT_W-1:0] wdata,
    output logic             busy,
    output logic             clk_out,
    output logic             tick
);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] div_act;
    logic [CNT_W-1:0] div_pend;
    logic [CNT_W-1:0] cnt_nxt;
    logic [CNT_W-1:0] half;
    logic [CNT_W-1:0] div_new;
    logic             wrap;
    logic             apply;

    always_comb begin
        wrap    = (cnt == div_act - CNT_W'(1));
        cnt_nxt = wrap ? '0 : cnt + CNT_W'(1);
        half    = div_act >> 1;
        apply   = !en || sync || wrap;
        // A write landing on an apply point bypasses the pending register.
        div_new = wr ? wdata : div_pend;
    end

    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            cnt      <= '0;
            div_act  <= CNT_W'(DEFAULT_DIV);
            div_pend <= CNT_W'(DEFAULT_DIV);
            busy     <= 1'b0;
            clk_out  <= 1'b0;
            tick     <= 1'b0;
        end else begin
            if (!en || sync) begin
                cnt     <= '0;
                clk_out <= 1'b0;
                tick    <= 1'b0;
            end else begin
                cnt     <= cnt_nxt;
                clk_out <= (cnt_nxt >= half);
                tick    <= wrap;
            end

            if (apply) begin
                if (wr || busy)
                    div_act <= div_new;
                busy <= 1'b0;
            end else if (wr) begin
                div_pend <= wdata;
                busy     <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/prog_clkdiv.sv
// Multi-channel run-time programmable clock divider.
// Decodes divisor writes into per-channel strobes and fans sync out to every channel.
module prog_clkdiv
    import prog_clkdiv_pkg::*;
#(
    parameter int NUM_CH      = 4,
    parameter int CNT_W       = 16,
    parameter int DEFAULT_DIV = 2
) (
    input  logic                       clk_in,
    input  logic                       reset,
    input  logic [NUM_CH-1:0]          en,
    input  logic                       sync,
    input  logic                       div_wr,
    input  logic [idx_w(NUM_CH)-1:0]   div_ch,
    input  logic [CNT_W-1:0]           div_data,
    output logic [NUM_CH-1:0]          div_busy,
    output logic [NUM_CH-1:0]          clk_out,
    output logic [NUM_CH-1:0]          tick
);

    localparam int IDX_W = idx_w(NUM_CH);

    logic [CNT_W-1:0]  div_clamped;
    logic [NUM_CH-1:0] wr_sel;

    assign div_clamped = CNT_W'(clamp_div(32'(div_data)));

    // An index with no matching channel selects nothing, so the write is dropped.
    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        assign wr_sel[i] = div_wr && (div_ch == IDX_W'(i));

        prog_clkdiv_chan #(
            .CNT_W       (CNT_W),
            .DEFAULT_DIV (DEFAULT_DIV)
        ) u_chan (
            .clk_in  (clk_in),
            .reset   (reset),
            .en      (en[i]),
            .sync    (sync),
            .wr      (wr_sel[i]),
            .wdata   (div_clamped),
            .busy    (div_busy[i]),
            .clk_out (clk_out[i]),
            .tick    (tick[i])
        );
    end

endmodule
